// File: rtl/sipo_deframer.sv
// sipo_deframer: serial-to-parallel word assembler with frame alignment and output handshake
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   serial_in    one data bit per clock
//   frame_start  marks the cycle carrying the first bit of a word
//   parallel_out assembled word, valid while out_valid is high
//   out_valid    word available, held until accepted
//   out_ready    consumer accepts on any edge with out_valid high
//   busy         frame partially received
//   frame_err    one-cycle pulse when a frame restarts early
//   overrun      one-cycle pulse when a finished word is dropped
module sipo_deframer #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial_in,
    input  logic             frame_start,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    typedef enum logic {IDLE, SHIFT} state_t;
    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d, idx, pos;
    logic [WIDTH-1:0] shift_q, shift_d, word, out_q, out_d;
    logic             valid_q, valid_d, err_q, err_d, ovr_q, ovr_d;
    logic             capture, done, load;
    always_comb begin
        capture = frame_start || state_q == SHIFT;
        // a frame_start always restarts at bit 0, even mid-frame
        idx     = frame_start ? '0 : cnt_q;
        pos     = MSB_FIRST ? LAST - idx : idx;
        done    = capture && idx == LAST;
        word    = frame_start ? '0 : shift_q;
        word[pos] = serial_in;
        shift_d = capture ? word : shift_q;
        cnt_d   = done ? '0 : capture ? idx + CW'(1) : cnt_q;
        state_d = done ? IDLE : capture ? SHIFT : state_q;
        // the output slot is free if empty or being drained on this same edge
        load    = done && (!valid_q || out_ready);
        out_d   = load ? word : out_q;
        valid_d = load ? 1'b1 : (valid_q && out_ready) ? 1'b0 : valid_q;
        ovr_d   = done && valid_q && !out_ready;
        err_d   = frame_start && state_q == SHIFT;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
        end
    end
    assign parallel_out = out_q;
    assign out_valid    = valid_q;
    assign busy         = state_q == SHIFT;
    assign frame_err    = err_q;
    assign overrun      = ovr_q;
endmodule

// File: tb/tb_sipo_deframer.sv
// tb_sipo_deframer: directed checks of an MSB-first and an LSB-first deframer sharing one stimulus
module tb_sipo_deframer;
    logic       clk = 1'b0, rst_n = 1'b1, serial_in = 1'b0, frame_start = 1'b0, out_ready = 1'b1;
    logic [3:0] pout_m, pout_l;
    logic       valid_m, valid_l, busy_m, busy_l, err_m, err_l, ovr_m, ovr_l;
    int         checks = 0, errors = 0;

    sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .frame_start(frame_start),
        .parallel_out(pout_m), .out_valid(valid_m), .out_ready(out_ready),
        .busy(busy_m), .frame_err(err_m), .overrun(ovr_m));
    sipo_deframer #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
        .clk(clk), .rst_n(rst_n), .serial_in(serial_in), .frame_start(frame_start),
        .parallel_out(pout_l), .out_valid(valid_l), .out_ready(out_ready),
        .busy(busy_l), .frame_err(err_l), .overrun(ovr_l));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic fs, input logic s);
        frame_start = fs;
        serial_in   = s;
        @(posedge clk);
        #1;
    endtask

    // status = {valid_m, valid_l, busy_m, busy_l, err_m, err_l, ovr_m, ovr_l}
    function automatic logic [7:0] st();
        return {valid_m, valid_l, busy_m, busy_l, err_m, err_l, ovr_m, ovr_l};
    endfunction

    initial begin
        #2 rst_n = 1'b0;
        #1;
        chk("reset_async_status", st(), 8'h00);
        chk("reset_async_pout", {pout_m, pout_l}, 8'h00);
        bit_in(1'b1, 1'b1);
        chk("reset_held_ignores_start", st(), 8'h00);
        rst_n = 1'b1;
        bit_in(1'b0, 1'b1);
        chk("idle_ignores_serial", st(), 8'h00);

        // 1,0,1,1 with out_ready high
        bit_in(1'b1, 1'b1);
        chk("f1_e0", st(), 8'b0011_0000);
        bit_in(1'b0, 1'b0);
        chk("f1_e1", st(), 8'b0011_0000);
        bit_in(1'b0, 1'b1);
        chk("f1_e2", st(), 8'b0011_0000);
        bit_in(1'b0, 1'b1);
        chk("f1_done_status", st(), 8'b1100_0000);
        chk("f1_msb_word", pout_m, 4'b1011);
        chk("f1_lsb_word", pout_l, 4'b1101);
        bit_in(1'b0, 1'b0);
        chk("f1_accepted", st(), 8'h00);
        chk("f1_word_kept", {pout_m, pout_l}, 8'b1011_1101);

        // 0110 then 1001 back to back under backpressure
        out_ready = 1'b0;
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        chk("f2_done_status", st(), 8'b1100_0000);
        chk("f2_word", {pout_m, pout_l}, 8'b0110_0110);
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b0);
        chk("f3_no_change_mid", {pout_m, pout_l}, 8'b0110_0110);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b1);
        chk("f3_overrun", st(), 8'b1100_0011);
        chk("f3_word_dropped", {pout_m, pout_l}, 8'b0110_0110);
        bit_in(1'b0, 1'b0);
        chk("f3_overrun_pulse_ends", st(), 8'b1100_0000);

        // completion on the same edge as acceptance
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        out_ready = 1'b1;
        bit_in(1'b0, 1'b0);
        chk("f4_replace_status", st(), 8'b1100_0000);
        chk("f4_replace_word", {pout_m, pout_l}, 8'b1100_0011);
        bit_in(1'b0, 1'b0);
        chk("f4_accepted", st(), 8'h00);

        // early restart at count 2
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b1);
        chk("f5_frame_err", st(), 8'b0011_1100);
        bit_in(1'b0, 1'b1);
        chk("f5_err_pulse_ends", st(), 8'b0011_0000);
        bit_in(1'b0, 1'b1);
        chk("f5_not_done_yet", st(), 8'b0011_0000);
        bit_in(1'b0, 1'b1);
        chk("f5_done_status", st(), 8'b1100_0000);
        chk("f5_word", {pout_m, pout_l}, 8'b1111_1111);
        bit_in(1'b0, 1'b0);

        // restart on the edge that would have captured the last bit
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b0);
        bit_in(1'b1, 1'b1);
        chk("f6_restart_at_last", st(), 8'b0011_1100);
        bit_in(1'b0, 1'b0);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b0);
        chk("f6_done_status", st(), 8'b1100_0000);
        chk("f6_word", {pout_m, pout_l}, 8'b1010_0101);

        // asynchronous reset mid-frame with a word still held
        out_ready = 1'b0;
        bit_in(1'b1, 1'b1);
        bit_in(1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_status", st(), 8'h00);
        chk("rst_mid_pout", {pout_m, pout_l}, 8'h00);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bit_in(1'b0, 1'b1);
            chk("post_rst_quiet", st(), 8'h00);
        end

        // first frame after reset release
        out_ready = 1'b1;
        bit_in(1'b1, 1'b0);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b1);
        bit_in(1'b0, 1'b1);
        chk("f7_done_status", st(), 8'b1100_0000);
        chk("f7_word", {pout_m, pout_l}, 8'b0111_1110);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
